// File: rtl/sudoku_pkg.sv
// Shared types and constants for the sudoku puzzle datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sudoku_pkg;

  localparam int BOARD_N = 9;
  localparam int CELLS   = 81;
  localparam int CELL_W  = 5;

  // One ROM cell: reserved tag bit above the 4-bit digit (0 = empty).
  typedef struct packed {
    logic       tag;
    logic [3:0] digit;
  } cell_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_SKIP   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // Row-major linear index of a board coordinate.
  function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
    return 7'(row) * 7'd9 + 7'(col);
  endfunction

endpackage

// File: rtl/sudoku_map_reader_rc_counter.sv
// Row/column position counter over a 9x9 board, row-major, with wrap.
// Latency: position updates on the edge where clr or en is high; lookahead is combinational.
// Backpressure: holds position while en is low; clr has priority over en.
module rc_counter
  import sudoku_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] nxt_row,
  output logic [3:0] nxt_col,
  output logic       at_last
);

  localparam logic [3:0] MAX_IDX = 4'(BOARD_N - 1);

  // Lookahead position and end-of-board flag.
  always_comb begin
    nxt_col = (col == MAX_IDX) ? 4'd0 : col + 4'd1;
    nxt_row = (col == MAX_IDX) ? row + 4'd1 : row;
    at_last = (row == MAX_IDX) && (col == MAX_IDX);
  end

  // Position register: clear to (0,0) or step to the lookahead position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= 4'd0;
      col <= 4'd0;
    end else if (clr) begin
      row <= 4'd0;
      col <= 4'd0;
    end else if (en) begin
      row <= nxt_row;
      col <= nxt_col;
    end
  end

endmodule

// File: rtl/sudoku_map_reader.sv
// Selects one puzzle from the packed ROM bus and streams its 81 cells row-major.
// Latency: start sampled at edge N, cell 0 valid after edge N+1; one cell per cycle thereafter.
// Backpressure: valid/ready; all cell outputs hold while cell_ready is low.
module sudoku_map_reader
  import sudoku_pkg::*;
#(
  parameter int MAP_COUNT  = 15,
  parameter int CELL_W     = 5,
  parameter bit SKIP_EMPTY = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [MAP_COUNT*81*CELL_W-1:0]  maps,
  input  logic                            start,
  input  logic [3:0]                      map_sel,
  output logic                            cell_valid,
  input  logic                            cell_ready,
  output logic [3:0]                      cell_row,
  output logic [3:0]                      cell_col,
  output logic [3:0]                      cell_value,
  output logic                            cell_tag,
  output logic                            cell_last,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  state_t            state, state_nxt;
  logic [3:0]        map_q;
  logic              pend_q;
  logic [3:0]        value_q;
  logic              tag_q;
  logic              err_q;
  logic [3:0]        row, col, nxt_row, nxt_col;
  logic              at_last;
  logic              in_range, accept, reject, advance, load;
  logic [6:0]        fetch_k;
  logic [CELL_W-1:0] raw;
  cell_t             cur;
  logic              cur_empty;

  rc_counter u_rc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pend_q),
    .en      (advance),
    .row     (row),
    .col     (col),
    .nxt_row (nxt_row),
    .nxt_col (nxt_col),
    .at_last (at_last)
  );

  // Request qualification and the cell about to be loaded into the output flops.
  // A pending accept loads cell 0; otherwise the lookahead position is fetched.
  always_comb begin
    in_range  = 32'(map_sel) < MAP_COUNT;
    accept    = (state == S_IDLE) && !pend_q && start && in_range;
    reject    = (state == S_IDLE) && !pend_q && start && !in_range;
    advance   = !at_last && (((state == S_STREAM) && cell_ready) || (state == S_SKIP));
    load      = pend_q || advance;
    fetch_k   = pend_q ? 7'd0 : cell_index(nxt_row, nxt_col);
    raw       = maps[(32'(map_q) * CELLS + 32'(fetch_k)) * CELL_W +: CELL_W];
    cur       = cell_t'(raw[4:0]);
    cur_empty = SKIP_EMPTY && (cur.digit == 4'd0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (pend_q) state_nxt = cur_empty ? S_SKIP : S_STREAM;
      S_STREAM: if (cell_ready) begin
                  if (at_last) state_nxt = S_FINISH;
                  else         state_nxt = cur_empty ? S_SKIP : S_STREAM;
                end
      S_SKIP:   if (at_last) state_nxt = S_FINISH;
                else         state_nxt = cur_empty ? S_SKIP : S_STREAM;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Latched map index, accept/reject pulses and the registered cell payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q   <= 4'd0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      value_q <= 4'd0;
      tag_q   <= 1'b0;
    end else begin
      pend_q <= accept;
      err_q  <= reject;
      if (accept) map_q <= map_sel;
      if (load) begin
        value_q <= cur.digit;
        tag_q   <= cur.tag;
      end
    end
  end

  // Outputs decoded from flops only.
  always_comb begin
    cell_valid = (state == S_STREAM);
    cell_row   = row;
    cell_col   = col;
    cell_value = value_q;
    cell_tag   = tag_q;
    cell_last  = cell_valid && at_last;
    busy       = (state == S_STREAM) || (state == S_SKIP);
    done       = (state == S_FINISH);
    err        = err_q;
  end

endmodule

// File: tb/tb_sudoku_map_reader.sv
module tb_sudoku_map_reader;

  localparam int MC = 15;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [MC*81*CW-1:0] maps;

  logic start0 = 1'b0, rdy0 = 1'b0;
  logic [3:0] sel0 = 4'd0;
  logic valid0, tag0, last0, busy0, done0, err0;
  logic [3:0] row0, col0, val0;

  logic start1 = 1'b0, rdy1 = 1'b0;
  logic [3:0] sel1 = 4'd0;
  logic valid1, tag1, last1, busy1, done1, err1;
  logic [3:0] row1, col1, val1;

  int rom [MC][81];
  int rtag [MC][81];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sudoku_map_reader #(.MAP_COUNT(MC), .CELL_W(CW), .SKIP_EMPTY(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .maps(maps), .start(start0), .map_sel(sel0),
    .cell_valid(valid0), .cell_ready(rdy0), .cell_row(row0), .cell_col(col0),
    .cell_value(val0), .cell_tag(tag0), .cell_last(last0), .busy(busy0),
    .done(done0), .err(err0));

  sudoku_map_reader #(.MAP_COUNT(MC), .CELL_W(CW), .SKIP_EMPTY(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .maps(maps), .start(start1), .map_sel(sel1),
    .cell_valid(valid1), .cell_ready(rdy1), .cell_row(row1), .cell_col(col1),
    .cell_value(val1), .cell_tag(tag1), .cell_last(last1), .busy(busy1),
    .done(done1), .err(err1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Streams map m on dut0 until stop_at cells have been accepted.
  task automatic stream0(input int m, input bit rnd, input bit midstart, input int stop_at);
    int k = 0;
    int cyc = 0;
    bit held_ok = 0;
    logic [13:0] held;
    @(negedge clk);
    start0 = 1'b1; sel0 = 4'(m);
    @(negedge clk);
    start0 = 1'b0;
    chk("pend_valid", valid0, 0);
    chk("pend_busy", busy0, 0);
    @(negedge clk);
    chk("lat_valid", valid0, 1);
    chk("lat_busy", busy0, 1);
    while (k < stop_at && cyc < 3000) begin
      rdy0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start0 = midstart && (k == 20);
      sel0 = 4'((m + 1) % MC);
      chk("valid_gap", valid0, 1);
      if (held_ok) chk("stall_stable", {row0, col0, val0, tag0, last0}, held);
      if (rdy0) begin
        chk("row", row0, k / 9);
        chk("col", col0, k % 9);
        chk("value", val0, rom[m][k]);
        chk("tag", tag0, rtag[m][k]);
        chk("last", last0, (k == 80));
        k++;
        held_ok = 0;
      end else begin
        held = {row0, col0, val0, tag0, last0};
        held_ok = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start0 = 1'b0;
    rdy0 = 1'b0;
    chk("xfer_count", k, stop_at);
    if (stop_at == 81) begin
      if (!rnd) chk("throughput", cyc, 81);
      chk("done_pulse", done0, 1);
      chk("done_busy", busy0, 0);
      chk("done_valid", valid0, 0);
      @(negedge clk);
      chk("done_once", done0, 0);
    end
  endtask

  initial begin
    int nz;
    int idx;
    int cyc;
    bit last_seen;
    int exp_k [$];

    for (int m = 0; m < MC; m++)
      for (int k = 0; k < 81; k++) begin
        rom[m][k]  = ($urandom_range(0, 99) < 40) ? 0 : int'($urandom_range(1, 9));
        rtag[m][k] = int'($urandom_range(0, 1));
      end
    rom[0][0]  = 0;
    rom[0][80] = 0;
    for (int m = 0; m < MC; m++)
      for (int k = 0; k < 81; k++)
        maps[(m*81+k)*CW +: CW] = {1'(rtag[m][k]), 4'(rom[m][k])};

    repeat (3) @(negedge clk);
    chk("rst_valid", valid0, 0);
    chk("rst_rowcol", {row0, col0}, 0);
    chk("rst_value", {val0, tag0, last0}, 0);
    chk("rst_flags", {busy0, done0, err0}, 0);
    rst_n = 1'b1;

    // Full maps with ready high, then the last map in the ROM.
    stream0(0, 0, 0, 81);
    stream0(14, 0, 0, 81);

    // Out-of-range selector.
    @(negedge clk);
    start0 = 1'b1; sel0 = 4'd15;
    @(negedge clk);
    start0 = 1'b0;
    chk("err_pulse", err0, 1);
    chk("err_busy", busy0, 0);
    chk("err_valid", valid0, 0);
    @(negedge clk);
    chk("err_once", err0, 0);
    chk("err_idle_valid", valid0, 0);
    chk("err_idle_busy", busy0, 0);

    // Random backpressure.
    stream0(3, 1, 0, 81);

    // Skip-empty instance on map 0 (cells 0 and 80 are empty).
    nz = 0;
    exp_k.delete();
    for (int k = 0; k < 81; k++) if (rom[0][k] != 0) begin nz++; exp_k.push_back(k); end
    @(negedge clk);
    start1 = 1'b1; sel1 = 4'd0; rdy1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    idx = 0; cyc = 0; last_seen = 0;
    while (!done1 && cyc < 400) begin
      if (valid1) begin
        if (last1) last_seen = 1;
        if (idx < exp_k.size()) begin
          chk("skip_row", row1, exp_k[idx] / 9);
          chk("skip_col", col1, exp_k[idx] % 9);
          chk("skip_value", val1, rom[0][exp_k[idx]]);
        end
        chk("skip_nonzero", (val1 != 4'd0), 1);
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    rdy1 = 1'b0;
    chk("skip_count", idx, nz);
    chk("skip_done", done1, 1);
    chk("skip_busy", busy1, 0);
    chk("skip_no_last", last_seen, 0);

    // Mid-stream start ignored, then asynchronous reset at cell 40.
    stream0(1, 0, 1, 40);
    chk("pre_rst_busy", busy0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", valid0, 0);
    chk("arst_rowcol", {row0, col0}, 0);
    chk("arst_value", {val0, tag0, last0}, 0);
    chk("arst_flags", {busy0, done0, err0}, 0);
    @(negedge clk);
    chk("arst_no_done", done0, 0);
    rst_n = 1'b1;
    stream0(2, 0, 0, 81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sudoku_map_reader.md
# sudoku_map_reader

Consumer side of the packed puzzle ROM. It takes the flat `maps` bus from the map-definition block and, on request, selects one puzzle. It then streams that puzzle's 81 cells in row-major order over a valid/ready interface to the board loader. It sits between the constant map store and the solver's board register file.

## Interface
Parameters:
- `MAP_COUNT`, 15: number of puzzles packed on `maps`.
- `CELL_W`, 5: bits per cell. Bits [3:0] hold the digit (0 = empty, 1..9 = given); bit [4] is reserved and forwarded as `cell_tag`.
- `SKIP_EMPTY`, 0: when 1, cells with digit 0 are consumed internally and not emitted.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `maps`  in  MAP_COUNT*81*CELL_W  packed ROM. Cell k of map m = `maps[(m*81+k)*CELL_W +: CELL_W]`, k = row*9+col.
- `start`  in  1  request pulse/level, sampled only in IDLE.
- `map_sel`  in  4  puzzle index, sampled with `start`.
- `cell_valid`  out  1  output cell available.
- `cell_ready`  in  1  downstream accepts the cell.
- `cell_row`, `cell_col`  out  4 each  coordinates 0..8.
- `cell_value`  out  4  digit field.
- `cell_tag`  out  1  bit [4] of the cell.
- `cell_last`  out  1  marks the cell with k = 80 when it is emitted.
- `busy`  out  1  high from acceptance until `done`.
- `done`  out  1  one-cycle pulse after the final cell completes.
- `err`  out  1  one-cycle pulse when a start is rejected.

## Operation
FSM states: IDLE, STREAM, SKIP, FINISH.
- **IDLE:**
  - On `start`=1 with `map_sel` < MAP_COUNT: latch `map_sel`, set k=0, go to STREAM.
  - On `start`=1 with `map_sel` ≥ MAP_COUNT: pulse `err`, stay in IDLE.
- **STREAM:**
  - `cell_valid`=1. Outputs are decoded from the latched map index and k. Row/col are held as separate 0..8 counters; col wraps 8→0 and increments row.
  - A transfer occurs when `cell_valid`&`cell_ready`. On transfer with k<80, k advances.
  - On transfer with k=80, go to FINISH.
  - With `cell_ready`=0, all outputs hold stable and k does not advance.
- **SKIP** (only when SKIP_EMPTY=1):
  - When the current cell's digit is 0, `cell_valid`=0 and k advances one cell per cycle.
  - When a non-empty cell is reached, return to STREAM.
  - If the skipped cell is k=80, go to FINISH.
- **FINISH:** pulse `done` for one cycle, drop `busy`, return to IDLE.
- `start` in any state other than IDLE is ignored. The latched map does not change mid-stream.
- `cell_last`=1 only when k=80 and `cell_valid`=1. With SKIP_EMPTY=1 and cell 80 empty, no cell carries `cell_last`; `done` still pulses.
- `maps` is treated as constant. It is not registered; only the index and counters are state.
- Output decode is a registered mux: `cell_*` come from flops updated on transfer or skip, not combinationally from k.

## Timing
- Reset values: IDLE, k=0, `cell_valid`=0, `cell_row`=`cell_col`=`cell_value`=0, `cell_tag`=0, `cell_last`=0, `busy`=0, `done`=0, `err`=0.
- Latency: `start` accepted at edge N gives `cell_valid`=1 with cell 0 after edge N+1. `busy`=1 from edge N+1.
- Throughput: one cell per cycle with `cell_ready` tied high. Full map with SKIP_EMPTY=0: 81 transfer cycles, then `done` one cycle later.
- `done` is asserted the cycle after the k=80 transfer. A new `start` is accepted no earlier than the cycle after `done`.
- `err` is asserted the cycle after the rejected `start`.
- Asynchronous `rst_n` assertion mid-stream returns all outputs to their reset values immediately. No partial `done` is produced.

## Structure
- Shared package `sudoku_pkg`:
  - `BOARD_N`=9, `CELLS`=81, `CELL_W`=5.
  - Cell struct typedef: tag + digit.
  - FSM state enum.
  - `cell_index(row,col)` function.
- One natural sub-module, `rc_counter`: row/col 0..8 counter with enable, wrap and `at_last` flag.

## Test plan
- Map 0, `cell_ready`=1, SKIP_EMPTY=0 → 81 transfers, rows/cols 0,0…8,8 in order, digits match ROM, `cell_last` only on cell (8,8), `done` 1 cycle later.
- Map 14 (last) → cell 0 comes from bit offset 14*405; `busy` drops with `done`.
- `map_sel`=15 → `err` pulses once, `busy` and `cell_valid` stay 0.
- Random `cell_ready` stalls on map 3 → outputs stable during each stall, no duplicate or dropped cell, 81 transfers total.
- SKIP_EMPTY=1 on map 0 → emitted count equals the ROM non-zero digit count; no `cell_value`=0 is emitted.
- `rst_n` low at cell 40 → outputs cleared; a fresh `start` with map 2 restarts at (0,0). `start` pulsed mid-stream is ignored.
